// File: rtl/keypad_pkg.sv
// Shared key codes, operator and state encodings
// for the calculator keypad entry path.
package keypad_pkg;

  localparam logic [4:0] K_ADD = 5'd16;
  localparam logic [4:0] K_SUB = 5'd17;
  localparam logic [4:0] K_MUL = 5'd18;
  localparam logic [4:0] K_DIV = 5'd19;
  localparam logic [4:0] K_CLR = 5'd20;
  localparam logic [4:0] K_EQ  = 5'd21;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_REQ  = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  function automatic logic [4:0] pos2code(
    input logic [3:0] pos
  );
    logic [4:0] c;
    unique case (pos)
      4'd0:  c = 5'd1;
      4'd1:  c = 5'd2;
      4'd2:  c = 5'd3;
      4'd3:  c = K_ADD;
      4'd4:  c = 5'd4;
      4'd5:  c = 5'd5;
      4'd6:  c = 5'd6;
      4'd7:  c = K_SUB;
      4'd8:  c = 5'd7;
      4'd9:  c = 5'd8;
      4'd10: c = 5'd9;
      4'd11: c = K_MUL;
      4'd12: c = K_CLR;
      4'd13: c = 5'd0;
      4'd14: c = K_EQ;
      4'd15: c = K_DIV;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Operand handoff from keypad entry to the ALU:
// req held until a one-cycle ack.
interface keypad_entry_ctrl_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] operand_a;
  logic [4*NDIG-1:0] operand_b;
  logic [1:0]        op;
  logic              calc_req;
  logic              calc_ack;

  modport master (
    output operand_a,
    output operand_b,
    output op,
    output calc_req,
    input  calc_ack
  );

  modport slave (
    input  operand_a,
    input  operand_b,
    input  op,
    input  calc_req,
    output calc_ack
  );
endinterface

// File: rtl/key_debounce.sv
// Tick-sampled press/release debouncer; one
// event per physical press with decoded code.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 131072,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_pos,
  input  logic       key_down,
  output logic       key_evt,
  output logic [4:0] key_code
);
  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW =
    $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TMAX =
    TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX =
    DW'(DEBOUNCE_TICKS);

  logic [TW-1:0] tcnt;
  logic          tick;
  logic          armed;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] pcnt;
  logic [3:0]    last;

  assign tick = (tcnt == TMAX);
  // a new position restarts the run at one
  assign pcnt =
    (dcnt != '0 && key_pos == last)
      ? dcnt + 1'b1 : DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt     <= '0;
      armed    <= 1'b1;
      dcnt     <= '0;
      last     <= '0;
      key_evt  <= 1'b0;
      key_code <= '0;
    end else begin
      key_evt <= 1'b0;
      tcnt    <= tick ? '0 : tcnt + 1'b1;
      if (tick) begin
        if (armed) begin
          if (!key_down) begin
            dcnt <= '0;
          end else if (pcnt == DMAX) begin
            key_evt  <= 1'b1;
            key_code <= pos2code(key_pos);
            armed    <= 1'b0;
            dcnt     <= '0;
          end else begin
            dcnt <= pcnt;
            last <= key_pos;
          end
        end else begin
          if (key_down) begin
            dcnt <= '0;
          end else if (dcnt + 1'b1 == DMAX) begin
            armed <= 1'b1;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// Calculator entry FSM: assembles two BCD
// operands and an operator, hands them to the ALU.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 131072,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int NDIG           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_pos,
  input  logic       key_down,
  keypad_entry_ctrl_if.master calc,
  output logic       key_evt,
  output logic [4:0] key_code,
  output logic       entry_ovf,
  output logic [1:0] state
);
  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] FULL = CW'(NDIG);

  state_t        st_q, st_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  op_t           op_q, op_d;
  logic [CW-1:0] ac_q, ac_d, bc_q, bc_d;
  logic          ovf_q, ovf_d;
  logic          req_q, req_d;
  logic          is_dig, is_op, is_clr, is_eq;
  logic          clr_all, load;
  logic [3:0]    digit;

  key_debounce #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .key_pos (key_pos),
    .key_down(key_down),
    .key_evt (key_evt),
    .key_code(key_code)
  );

  assign digit  = key_code[3:0];
  assign is_dig = key_code < 5'd10;
  assign is_op  = key_code >= K_ADD &&
                  key_code <= K_DIV;
  assign is_clr = key_code == K_CLR;
  assign is_eq  = key_code == K_EQ;

  always_comb begin
    st_d    = st_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ac_d    = ac_q;
    bc_d    = bc_q;
    ovf_d   = ovf_q;
    req_d   = 1'b0;
    clr_all = 1'b0;
    load    = 1'b0;
    unique case (st_q)
      S_A: if (key_evt) begin
        unique case (1'b1)
          is_dig:
            if (ac_q == FULL) ovf_d = 1'b1;
            else begin
              a_d  = {a_q[W-5:0], digit};
              ac_d = ac_q + 1'b1;
            end
          is_op: begin
            op_d = op_t'(key_code[1:0]);
            st_d = S_B;
          end
          is_clr: clr_all = 1'b1;
          is_eq: ;
        endcase
      end
      S_B: if (key_evt) begin
        unique case (1'b1)
          is_dig:
            if (bc_q == FULL) ovf_d = 1'b1;
            else begin
              b_d  = {b_q[W-5:0], digit};
              bc_d = bc_q + 1'b1;
            end
          is_op:
            if (bc_q == '0)
              op_d = op_t'(key_code[1:0]);
          is_clr: clr_all = 1'b1;
          is_eq:
            if (bc_q != '0) st_d = S_REQ;
        endcase
      end
      // keys are ignored until the ALU takes the operands
      S_REQ:
        if (req_q && calc.calc_ack) st_d = S_SHOW;
        else req_d = 1'b1;
      S_SHOW: if (key_evt) begin
        unique case (1'b1)
          is_dig: begin
            clr_all = 1'b1;
            load    = 1'b1;
          end
          is_clr: clr_all = 1'b1;
          is_op, is_eq: ;
        endcase
      end
    endcase
    if (clr_all) begin
      st_d  = S_A;
      a_d   = '0;
      b_d   = '0;
      op_d  = OP_ADD;
      ac_d  = '0;
      bc_d  = '0;
      ovf_d = 1'b0;
    end
    if (load) begin
      a_d  = W'(digit);
      ac_d = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      ac_q  <= '0;
      bc_q  <= '0;
      ovf_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      ac_q  <= ac_d;
      bc_q  <= bc_d;
      ovf_q <= ovf_d;
      req_q <= req_d;
    end
  end

  assign calc.operand_a = a_q;
  assign calc.operand_b = b_q;
  assign calc.op        = op_q;
  assign calc.calc_req  = req_q;
  assign entry_ovf      = ovf_q;
  assign state          = st_q;
endmodule
